// File: rtl/huffman_encoder.sv
// huffman_encoder: looks up each incoming symbol in a run-time programmable
// code table and packs the variable-length codes MSB-first into OUT_WIDTH-bit
// words. A flush drains the final partial word, zero-padded in its LSBs,
// and then pulses flush_done for one cycle.
module huffman_encoder #(
    parameter int SYM_WIDTH    = 5,
    parameter int MAX_CODE_LEN = 10,
    parameter int OUT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tbl_we,
    input  logic [SYM_WIDTH-1:0]    tbl_addr,
    input  logic [MAX_CODE_LEN-1:0] tbl_code,
    input  logic [3:0]              tbl_len,
    input  logic                    sym_valid,
    output logic                    sym_ready,
    input  logic [SYM_WIDTH-1:0]    sym_data,
    input  logic                    flush,
    output logic                    flush_done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_WIDTH-1:0]    out_data,
    output logic [5:0]              out_bits,
    output logic                    err_len
);

    // The accumulator holds one full word plus the longest code, so a code
    // can always be appended while fill is still below OUT_WIDTH.
    localparam int ACC_W  = OUT_WIDTH + MAX_CODE_LEN;
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam int DEPTH  = 1 << SYM_WIDTH;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Lengths above MAX_CODE_LEN are clamped so the accumulator cannot overflow.
    function automatic logic [3:0] cap_len(input logic [3:0] len);
        if (len > 4'(MAX_CODE_LEN)) begin
            return 4'(MAX_CODE_LEN);
        end else begin
            return len;
        end
    endfunction

    // Right-aligned code masked to len bits and moved so that its MSB lands
    // directly below the fill bits already occupying the top of the accumulator.
    function automatic logic [ACC_W-1:0] place_code(
        input logic [MAX_CODE_LEN-1:0] code,
        input logic [3:0]              len,
        input logic [FILL_W-1:0]       fill
    );
        logic [ACC_W-1:0]  mask;
        logic [FILL_W-1:0] sh;
        mask = (ACC_W'(1) << len) - ACC_W'(1);
        sh   = FILL_W'(ACC_W) - fill - FILL_W'(len);
        return (ACC_W'(code) & mask) << sh;
    endfunction

    logic [MAX_CODE_LEN-1:0] tbl_code_r [DEPTH];
    logic [3:0]              tbl_len_r  [DEPTH];

    logic [ACC_W-1:0]  acc_r;
    logic [FILL_W-1:0] fill_r;
    state_t            state_r;
    logic              err_len_r;

    logic                    sym_ready_s;
    logic                    out_valid_s;
    logic                    accept_s;
    logic                    emit_s;
    logic [FILL_W-1:0]       take_s;
    logic [3:0]              cur_len_s;
    logic [MAX_CODE_LEN-1:0] cur_code_s;
    logic [ACC_W-1:0]        acc_nxt_s;
    logic [FILL_W-1:0]       fill_nxt_s;
    state_t                  state_nxt_s;

    // Handshake and output decode derived from the registered state.
    always_comb begin
        sym_ready_s = (state_r == ST_RUN) && (fill_r < FILL_W'(OUT_WIDTH)) && !rst;
        if (((state_r == ST_RUN) || (state_r == ST_FLUSH)) && (fill_r >= FILL_W'(OUT_WIDTH))) begin
            out_valid_s = 1'b1;
        end else if ((state_r == ST_FLUSH) && (fill_r != FILL_W'(0))) begin
            out_valid_s = 1'b1;
        end else begin
            out_valid_s = 1'b0;
        end
        if (fill_r >= FILL_W'(OUT_WIDTH)) begin
            take_s = FILL_W'(OUT_WIDTH);
        end else begin
            take_s = fill_r;
        end
        accept_s   = sym_valid && sym_ready_s;
        emit_s     = out_valid_s && out_ready;
        cur_len_s  = cap_len(tbl_len_r[sym_data]);
        cur_code_s = tbl_code_r[sym_data];
    end

    // Next accumulator, fill and state; accept and emit are mutually exclusive.
    always_comb begin
        acc_nxt_s   = acc_r;
        fill_nxt_s  = fill_r;
        state_nxt_s = state_r;
        if (accept_s) begin
            acc_nxt_s  = acc_r | place_code(cur_code_s, cur_len_s, fill_r);
            fill_nxt_s = fill_r + FILL_W'(cur_len_s);
        end else if (emit_s) begin
            acc_nxt_s  = acc_r << take_s;
            fill_nxt_s = fill_r - take_s;
        end else begin
            acc_nxt_s  = acc_r;
            fill_nxt_s = fill_r;
        end
        case (state_r)
            ST_RUN: begin
                if (flush) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (fill_nxt_s == FILL_W'(0)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_RUN;
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Code table: cleared by reset, written only through the tbl_* port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_code_r[i] <= '0;
                tbl_len_r[i]  <= 4'd0;
            end
        end else if (tbl_we) begin
            tbl_code_r[tbl_addr] <= tbl_code;
            tbl_len_r[tbl_addr]  <= tbl_len;
        end
    end

    // Packing datapath, flush state machine and sticky length error.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r     <= '0;
            fill_r    <= '0;
            state_r   <= ST_RUN;
            err_len_r <= 1'b0;
        end else begin
            acc_r   <= acc_nxt_s;
            fill_r  <= fill_nxt_s;
            state_r <= state_nxt_s;
            if (accept_s && (tbl_len_r[sym_data] == 4'd0)) begin
                err_len_r <= 1'b1;
            end
        end
    end

    assign sym_ready  = sym_ready_s;
    assign out_valid  = out_valid_s;
    assign out_data   = acc_r[ACC_W-1 -: OUT_WIDTH];
    assign out_bits   = 6'(take_s);
    assign flush_done = (state_r == ST_DONE);
    assign err_len    = err_len_r;

endmodule

// File: tb/tb_huffman_encoder.sv
// Directed testbench for huffman_encoder with hand-computed expectations.
module tb_huffman_encoder;

    logic        clk;
    logic        rst;
    logic        tbl_we;
    logic [4:0]  tbl_addr;
    logic [9:0]  tbl_code;
    logic [3:0]  tbl_len;
    logic        sym_valid;
    logic        sym_ready;
    logic [4:0]  sym_data;
    logic        flush;
    logic        flush_done;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_bits;
    logic        err_len;

    int checks;
    int failures;

    huffman_encoder #(.SYM_WIDTH(5), .MAX_CODE_LEN(10), .OUT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_code(tbl_code), .tbl_len(tbl_len),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data),
        .flush(flush), .flush_done(flush_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_bits(out_bits),
        .err_len(err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [4:0] a, input logic [9:0] c, input logic [3:0] l);
        tbl_we = 1'b1; tbl_addr = a; tbl_code = c; tbl_len = l;
        step();
        tbl_we = 1'b0;
    endtask

    task automatic push(input logic [4:0] s);
        sym_valid = 1'b1; sym_data = s;
        step();
        sym_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++; if (sym_ready !== 1'b0) begin failures++; $display("FAIL rst_sym_ready got=%b exp=0", sym_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        checks++; if (out_bits !== 6'd0) begin failures++; $display("FAIL rst_out_bits got=%0d exp=0", out_bits); end
        checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL rst_flush_done got=%b exp=0", flush_done); end
        checks++; if (err_len !== 1'b0) begin failures++; $display("FAIL rst_err_len got=%b exp=0", err_len); end
        rst = 1'b0;
        #1;
        checks++; if (sym_ready !== 1'b1) begin failures++; $display("FAIL post_rst_sym_ready got=%b exp=1", sym_ready); end
    endtask

    task automatic test_packing();
        write_entry(5'd0, 10'b10, 4'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (sym_ready !== 1'b1) begin failures++; $display("FAIL pack_ready[%0d] got=%b exp=1", i, sym_ready); end
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pack_early_valid[%0d] got=%b exp=0", i, out_valid); end
            push(5'd0);
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pack_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 32'hAAAAAAAA) begin failures++; $display("FAIL pack_data got=%h exp=aaaaaaaa", out_data); end
        checks++; if (out_bits !== 6'd32) begin failures++; $display("FAIL pack_bits got=%0d exp=32", out_bits); end
        checks++; if (sym_ready !== 1'b0) begin failures++; $display("FAIL pack_full_ready got=%b exp=0", sym_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pack_consumed got=%b exp=0", out_valid); end
        checks++; if (out_bits !== 6'd0) begin failures++; $display("FAIL pack_left_bits got=%0d exp=0", out_bits); end
    endtask

    task automatic test_flush_two_words();
        write_entry(5'd7, 10'h3FF, 4'd10);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(5'd7);
        checks++; if (out_data !== 32'hFFFFFFFF) begin failures++; $display("FAIL fl_word0 got=%h exp=ffffffff", out_data); end
        checks++; if (out_bits !== 6'd32) begin failures++; $display("FAIL fl_bits0 got=%0d exp=32", out_bits); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fl_valid0 got=%b exp=1", out_valid); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fl_valid1 got=%b exp=1", out_valid); end
        checks++; if (out_data !== 32'hFF000000) begin failures++; $display("FAIL fl_word1 got=%h exp=ff000000", out_data); end
        checks++; if (out_bits !== 6'd8) begin failures++; $display("FAIL fl_bits1 got=%0d exp=8", out_bits); end
        checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL fl_done_early got=%b exp=0", flush_done); end
        step();
        checks++; if (flush_done !== 1'b1) begin failures++; $display("FAIL fl_done got=%b exp=1", flush_done); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fl_done_valid got=%b exp=0", out_valid); end
        checks++; if (sym_ready !== 1'b0) begin failures++; $display("FAIL fl_done_ready got=%b exp=0", sym_ready); end
        step();
        checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL fl_done_pulse got=%b exp=0", flush_done); end
        checks++; if (sym_ready !== 1'b1) begin failures++; $display("FAIL fl_ready_back got=%b exp=1", sym_ready); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(5'd7);
        sym_valid = 1'b1; sym_data = 5'd7;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, out_valid); end
            checks++; if (out_data !== 32'hFFFFFFFF) begin failures++; $display("FAIL bp_data[%0d] got=%h exp=ffffffff", i, out_data); end
            checks++; if (out_bits !== 6'd32) begin failures++; $display("FAIL bp_bits[%0d] got=%0d exp=32", i, out_bits); end
            checks++; if (sym_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, sym_ready); end
            step();
        end
        sym_valid = 1'b0;
        out_ready = 1'b1;
        step();
        checks++; if (sym_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after got=%b exp=1", sym_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_after got=%b exp=0", out_valid); end
        checks++; if (out_bits !== 6'd8) begin failures++; $display("FAIL bp_left_bits got=%0d exp=8", out_bits); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (out_data !== 32'hFF000000) begin failures++; $display("FAIL bp_tail got=%h exp=ff000000", out_data); end
        step();
        checks++; if (flush_done !== 1'b1) begin failures++; $display("FAIL bp_flush_done got=%b exp=1", flush_done); end
        step();
    endtask

    task automatic test_flush_empty();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL fe_done_c1 got=%b exp=0", flush_done); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fe_valid_c1 got=%b exp=0", out_valid); end
        step();
        checks++; if (flush_done !== 1'b1) begin failures++; $display("FAIL fe_done_c2 got=%b exp=1", flush_done); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fe_valid_c2 got=%b exp=0", out_valid); end
        step();
        checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL fe_done_c3 got=%b exp=0", flush_done); end
        checks++; if (sym_ready !== 1'b1) begin failures++; $display("FAIL fe_ready_c3 got=%b exp=1", sym_ready); end
    endtask

    task automatic test_err_len();
        checks++; if (err_len !== 1'b0) begin failures++; $display("FAIL err_initial got=%b exp=0", err_len); end
        push(5'd3);
        checks++; if (err_len !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", err_len); end
        checks++; if (out_bits !== 6'd0) begin failures++; $display("FAIL err_fill got=%0d exp=0", out_bits); end
        for (int i = 0; i < 16; i++) push(5'd0);
        checks++; if (out_data !== 32'hAAAAAAAA) begin failures++; $display("FAIL err_encode got=%h exp=aaaaaaaa", out_data); end
        checks++; if (err_len !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err_len); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL err_consumed got=%b exp=0", out_valid); end
    endtask

    task automatic test_table_collision();
        tbl_we = 1'b1; tbl_addr = 5'd4; tbl_code = 10'd1; tbl_len = 4'd1;
        sym_valid = 1'b1; sym_data = 5'd4;
        step();
        tbl_we = 1'b0; sym_valid = 1'b0;
        checks++; if (out_bits !== 6'd0) begin failures++; $display("FAIL col_old_entry got=%0d exp=0", out_bits); end
        push(5'd4);
        checks++; if (out_bits !== 6'd1) begin failures++; $display("FAIL col_new_entry got=%0d exp=1", out_bits); end
        write_entry(5'd5, 10'h2AB, 4'd15);
        push(5'd5);
        checks++; if (out_bits !== 6'd11) begin failures++; $display("FAIL cap_bits got=%0d exp=11", out_bits); end
        checks++; if (out_data !== 32'hD5600000) begin failures++; $display("FAIL cap_data got=%h exp=d5600000", out_data); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL cap_tail_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 32'hD5600000) begin failures++; $display("FAIL cap_tail_data got=%h exp=d5600000", out_data); end
        step();
        checks++; if (flush_done !== 1'b1) begin failures++; $display("FAIL cap_flush_done got=%b exp=1", flush_done); end
        step();
    endtask

    task automatic test_reset_mid();
        push(5'd7);
        push(5'd7);
        checks++; if (out_bits !== 6'd20) begin failures++; $display("FAIL rm_fill got=%0d exp=20", out_bits); end
        rst = 1'b1;
        #1;
        checks++; if (sym_ready !== 1'b0) begin failures++; $display("FAIL rm_ready_in_rst got=%b exp=0", sym_ready); end
        step();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%b exp=0", out_valid); end
        checks++; if (out_bits !== 6'd0) begin failures++; $display("FAIL rm_fill_cleared got=%0d exp=0", out_bits); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL rm_data got=%h exp=0", out_data); end
        checks++; if (err_len !== 1'b0) begin failures++; $display("FAIL rm_err got=%b exp=0", err_len); end
        checks++; if (sym_ready !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b exp=1", sym_ready); end
        push(5'd0);
        checks++; if (err_len !== 1'b1) begin failures++; $display("FAIL rm_table_cleared got=%b exp=1", err_len); end
        checks++; if (out_bits !== 6'd0) begin failures++; $display("FAIL rm_no_append got=%0d exp=0", out_bits); end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_code = '0; tbl_len = '0;
        sym_valid = 1'b0; sym_data = '0; flush = 1'b0; out_ready = 1'b0;
        test_reset();
        test_packing();
        test_flush_two_words();
        test_backpressure();
        test_flush_empty();
        test_err_len();
        test_table_collision();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
